// File: rtl/alu_issue_arbiter_pkg.sv
// Shared definitions for the execute-stage ALU issue arbiter: ALU function codes and operand payload.
package alu_issue_arbiter_pkg;

    localparam int unsigned ALU_FUNC_W = 4;
    localparam int unsigned DATA_W     = 32;

    localparam logic [ALU_FUNC_W-1:0] ALU_NONE = 4'h0;
    localparam logic [ALU_FUNC_W-1:0] ALU_ADD  = 4'h1;
    localparam logic [ALU_FUNC_W-1:0] ALU_SUB  = 4'h2;
    localparam logic [ALU_FUNC_W-1:0] ALU_AND  = 4'h3;
    localparam logic [ALU_FUNC_W-1:0] ALU_OR   = 4'h4;
    localparam logic [ALU_FUNC_W-1:0] ALU_XOR  = 4'h5;
    localparam logic [ALU_FUNC_W-1:0] ALU_SLL  = 4'h6;
    localparam logic [ALU_FUNC_W-1:0] ALU_SRL  = 4'h7;
    localparam logic [ALU_FUNC_W-1:0] ALU_SRA  = 4'h8;
    localparam logic [ALU_FUNC_W-1:0] ALU_SLT  = 4'h9;
    localparam logic [ALU_FUNC_W-1:0] ALU_SLTU = 4'hA;

    typedef struct packed {
        logic [ALU_FUNC_W-1:0] func;
        logic [DATA_W-1:0]     a;
        logic [DATA_W-1:0]     b;
    } alu_op_t;

    localparam alu_op_t ALU_OP_IDLE = '{func: ALU_NONE, a: '0, b: '0};

    function automatic alu_op_t pick_op(input logic sel, input alu_op_t op0, input alu_op_t op1);
        return sel ? op1 : op0;
    endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// Fixed-priority grant to requester 0 with a starvation counter that forces requester 1 through.
module alu_arb_grant #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_i,
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic accept_en,
    output logic grant_c,
    output logic req0_ready_c,
    output logic req1_ready_c
);

    localparam int unsigned        CNT_W   = 4;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             hs0;
    logic             hs1;

    // Requester 1 wins when requester 0 is idle or it has lost MAX_WAIT times in a row
    assign grant_c      = req1_valid & (!req0_valid | (starve_cnt == CNT_MAX));
    assign req0_ready_c = accept_en & !grant_c;
    assign req1_ready_c = accept_en &  grant_c;

    assign hs0 = req0_valid & req0_ready_c;
    assign hs1 = req1_valid & req1_ready_c;

    always_ff @(posedge clk) begin
        if (!rst_i) begin
            starve_cnt <= '0;
        end else if (hs1) begin
            starve_cnt <= '0;
        end else if (hs0 && req1_valid && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares the execute-stage ALU between the integer path (req0) and branch/AGU (req1):
// X stage drives the ALU, R stage holds the captured result for the response channel.
module alu_issue_arbiter
    import alu_issue_arbiter_pkg::*;
#(
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  hold_i,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [ALU_FUNC_W-1:0] req0_func_i,
    input  logic [DATA_W-1:0]     req0_a_i,
    input  logic [DATA_W-1:0]     req0_b_i,
    input  logic [TAG_W-1:0]      req0_tag_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [ALU_FUNC_W-1:0] req1_func_i,
    input  logic [DATA_W-1:0]     req1_a_i,
    input  logic [DATA_W-1:0]     req1_b_i,
    input  logic [TAG_W-1:0]      req1_tag_i,
    output logic [ALU_FUNC_W-1:0] alu_func_o,
    output logic [DATA_W-1:0]     alu_a_o,
    output logic [DATA_W-1:0]     alu_b_o,
    input  logic [DATA_W-1:0]     alu_result_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_id_o,
    output logic [TAG_W-1:0]      rsp_tag_o,
    output logic [DATA_W-1:0]     rsp_result_o,
    output logic                  busy_o
);

    logic              x_valid;
    alu_op_t           x_op;
    logic              x_id;
    logic [TAG_W-1:0]  x_tag;

    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_id;
    logic [TAG_W-1:0]  r_tag;

    logic              busy_q;

    logic              r_free;
    logic              x_adv;
    logic              accept_en;
    logic              rsp_hs;
    logic              grant;
    logic              accept;
    logic              x_valid_nxt;
    logic              r_valid_nxt;
    alu_op_t           in_op;

    assign r_free    = !r_valid | rsp_ready_i;
    assign x_adv     = x_valid & r_free & !hold_i;
    assign accept_en = !hold_i & (!x_valid | x_adv);
    assign rsp_hs    = r_valid & rsp_ready_i;

    alu_arb_grant #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .clk          (clk),
        .rst_i        (rst_i),
        .req0_valid   (req0_valid_i),
        .req1_valid   (req1_valid_i),
        .accept_en    (accept_en),
        .grant_c      (grant),
        .req0_ready_c (req0_ready_o),
        .req1_ready_c (req1_ready_o)
    );

    assign accept = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);
    assign in_op  = pick_op(grant,
                            '{func: req0_func_i, a: req0_a_i, b: req0_b_i},
                            '{func: req1_func_i, a: req1_a_i, b: req1_b_i});

    assign x_valid_nxt = accept | (x_valid & !x_adv);
    assign r_valid_nxt = x_adv  | (r_valid & !rsp_hs);

    // X is parked at ALU_OP_IDLE whenever empty so the ALU lines come straight from flops
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            x_valid  <= 1'b0;
            x_op     <= ALU_OP_IDLE;
            x_id     <= 1'b0;
            x_tag    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_id     <= 1'b0;
            r_tag    <= '0;
            busy_q   <= 1'b0;
        end else begin
            x_valid <= x_valid_nxt;
            if (accept) begin
                x_op  <= in_op;
                x_id  <= grant;
                x_tag <= grant ? req1_tag_i : req0_tag_i;
            end else if (x_adv) begin
                x_op  <= ALU_OP_IDLE;
            end

            r_valid <= r_valid_nxt;
            if (x_adv) begin
                r_result <= alu_result_i;
                r_id     <= x_id;
                r_tag    <= x_tag;
            end

            busy_q <= x_valid_nxt | r_valid_nxt;
        end
    end

    assign alu_func_o   = x_op.func;
    assign alu_a_o      = x_op.a;
    assign alu_b_o      = x_op.b;
    assign rsp_valid_o  = r_valid;
    assign rsp_id_o     = r_id;
    assign rsp_tag_o    = r_tag;
    assign rsp_result_o = r_result;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Randomised bench for alu_issue_arbiter against a transaction-queue model, plus directed literal checks.
module tb_alu_issue_arbiter;
    import alu_issue_arbiter_pkg::*;

    localparam int unsigned TAG_W    = 5;
    localparam int unsigned MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hold;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [3:0]        req0_func, req1_func;
    logic [31:0]       req0_a, req0_b, req1_a, req1_b;
    logic [TAG_W-1:0]  req0_tag, req1_tag;
    logic [3:0]        alu_func;
    logic [31:0]       alu_a, alu_b, alu_result;
    logic              rsp_valid, rsp_ready, rsp_id, busy;
    logic [TAG_W-1:0]  rsp_tag;
    logic [31:0]       rsp_result;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.TAG_W(TAG_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_i(rst_n), .hold_i(hold),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_func_i(req0_func),
        .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_tag_i(req0_tag),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_func_i(req1_func),
        .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_tag_i(req1_tag),
        .alu_func_o(alu_func), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_result_i(alu_result),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_tag_o(rsp_tag), .rsp_result_o(rsp_result), .busy_o(busy)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            default:  return 32'h0;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_func, alu_a, alu_b);

    // Model: ops in flight, oldest first; the front sits in R when head_in_r, the newest in X otherwise
    typedef struct {
        logic [3:0]       func;
        logic [31:0]      a, b;
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
    } op_t;

    op_t              inflight[$];
    bit               head_in_r;
    int               starve;
    int               passed = 0;
    int               total  = 0;
    bit               m_r_occ, m_x_occ, m_rsp_hs, m_x_adv, m_rdy0, m_rdy1;
    bit               hs0, hs1;
    bit               gnt_log[$];
    logic [TAG_W-1:0] rx_tags[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic predict();
        int  n;
        bit  acc_en, g1;
        n        = inflight.size();
        m_r_occ  = (n > 0) && head_in_r;
        m_x_occ  = (n == 2) || (n == 1 && !head_in_r);
        m_rsp_hs = m_r_occ && rsp_ready;
        m_x_adv  = m_x_occ && (!m_r_occ || rsp_ready) && !hold;
        acc_en   = !hold && (!m_x_occ || m_x_adv);
        g1       = req1_valid && (!req0_valid || starve == MAX_WAIT);
        m_rdy0   = acc_en && !g1;
        m_rdy1   = acc_en && g1;
    endtask

    task automatic model_update();
        op_t o;
        if (!rst_n) begin
            inflight.delete();
            head_in_r = 0;
            starve    = 0;
            return;
        end
        if (m_rsp_hs) void'(inflight.pop_front());
        if (m_x_adv) begin
            o = inflight[inflight.size()-1];
            o.res = ref_alu(o.func, o.a, o.b);
            inflight[inflight.size()-1] = o;
        end
        head_in_r = m_x_adv ? 1'b1 : (m_rsp_hs ? 1'b0 : head_in_r);
        if (inflight.size() == 0) head_in_r = 0;
        if (hs0 || hs1) begin
            o.id  = hs1;
            o.func = hs1 ? req1_func : req0_func;
            o.a   = hs1 ? req1_a : req0_a;
            o.b   = hs1 ? req1_b : req0_b;
            o.tag = hs1 ? req1_tag : req0_tag;
            o.res = '0;
            inflight.push_back(o);
            gnt_log.push_back(hs1);
        end
        if (hs1) starve = 0;
        else if (hs0 && req1_valid && starve < MAX_WAIT) starve++;
    endtask

    task automatic check_outputs();
        int  n;
        bit  r_occ, x_occ;
        op_t f, x;
        n     = inflight.size();
        r_occ = (n > 0) && head_in_r;
        x_occ = (n == 2) || (n == 1 && !head_in_r);
        chk("rsp_valid", rsp_valid, r_occ);
        chk("busy", busy, n > 0);
        if (x_occ) begin
            x = inflight[n-1];
            chk("alu_func", alu_func, x.func);
            chk("alu_a", alu_a, x.a);
            chk("alu_b", alu_b, x.b);
        end else begin
            chk("alu_func_idle", alu_func, ALU_NONE);
            chk("alu_a_idle", alu_a, 0);
            chk("alu_b_idle", alu_b, 0);
        end
        if (r_occ) begin
            f = inflight[0];
            chk("rsp_id", rsp_id, f.id);
            chk("rsp_tag", rsp_tag, f.tag);
            chk("rsp_result", rsp_result, f.res);
        end
    endtask

    // One clock: check combinational readys, clock the edge, check registered outputs
    task automatic step();
        #1;
        predict();
        chk("req0_ready", req0_ready, m_rdy0);
        chk("req1_ready", req1_ready, m_rdy1);
        hs0 = req0_valid && m_rdy0;
        hs1 = req1_valid && m_rdy1;
        if (rsp_valid && rsp_ready) rx_tags.push_back(rsp_tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_req0(input logic v, input logic [3:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [TAG_W-1:0] t);
        req0_valid = v; req0_func = f; req0_a = a; req0_b = b; req0_tag = t;
    endtask

    task automatic set_req1(input logic v, input logic [3:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [TAG_W-1:0] t);
        req1_valid = v; req1_func = f; req1_a = a; req1_b = b; req1_tag = t;
    endtask

    initial begin
        bit exp_gnt[10];
        int sent;
        exp_gnt = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        rst_n = 1'b0; hold = 1'b0; rsp_ready = 1'b1;
        set_req0(0, ALU_NONE, 0, 0, 0);
        set_req1(0, ALU_NONE, 0, 0, 0);
        head_in_r = 0; starve = 0;
        @(negedge clk);
        step(); step();
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_alu_func", alu_func, ALU_NONE);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_rsp_tag", rsp_tag, 0);
        rst_n = 1'b1;
        step();

        // Single req0 ADD: response two edges after acceptance
        chk("t1_func_before", alu_func, ALU_NONE);
        set_req0(1, ALU_ADD, 32'd5, 32'd7, 5'd3);
        step();
        set_req0(0, ALU_NONE, 0, 0, 0);
        chk("t1_alu_func", alu_func, ALU_ADD);
        chk("t1_no_rsp_yet", rsp_valid, 0);
        step();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_result", rsp_result, 32'd12);
        chk("t1_id", rsp_id, 0);
        chk("t1_tag", rsp_tag, 3);
        chk("t1_func_after", alu_func, ALU_NONE);
        step();
        chk("t1_rsp_once", rsp_valid, 0);

        // Both requesters valid continuously: starvation forces every fifth grant to req1
        gnt_log.delete();
        set_req0(1, ALU_ADD, 32'd1, 32'd1, 5'd0);
        set_req1(1, ALU_OR, 32'd2, 32'd4, 5'd16);
        for (int c = 0; c < 10; c++) begin
            step();
            if (hs0) set_req0(1, ALU_ADD, $urandom, $urandom, TAG_W'(c + 1));
            if (hs1) set_req1(1, ALU_OR, $urandom, $urandom, TAG_W'(c + 17));
        end
        chk("t2_grant_count", gnt_log.size(), 10);
        for (int i = 0; i < 10 && i < gnt_log.size(); i++)
            chk($sformatf("t2_grant_%0d", i), gnt_log[i], exp_gnt[i]);
        set_req0(0, ALU_NONE, 0, 0, 0);
        set_req1(0, ALU_NONE, 0, 0, 0);
        repeat (3) step();

        // req0 stream of 6 with response backpressure in cycles 3..6
        rx_tags.delete();
        sent = 0;
        for (int c = 1; c <= 20; c++) begin
            rsp_ready = !(c >= 3 && c <= 6);
            if (sent < 6) set_req0(1, ALU_XOR, $urandom, $urandom, TAG_W'(sent));
            else set_req0(0, ALU_NONE, 0, 0, 0);
            if (c == 5) begin
                #1;
                chk("t3_ready_low", req0_ready, 0);
                chk("t3_busy", busy, 1);
            end
            step();
            if (hs0) sent++;
        end
        chk("t3_rx_count", rx_tags.size(), 6);
        for (int i = 0; i < 6 && i < rx_tags.size(); i++)
            chk($sformatf("t3_rx_order_%0d", i), rx_tags[i], i);
        rsp_ready = 1'b1;

        // Fill X and R, then hold for 3 cycles
        rsp_ready = 1'b0;
        set_req0(1, ALU_ADD, 32'd10, 32'd20, 5'd8);
        step();
        set_req0(1, ALU_SUB, 32'd9, 32'd4, 5'd9);
        step();
        set_req0(1, ALU_AND, 32'hFF, 32'h0F, 5'd10);
        hold = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_no_accept", req0_ready, 0);
            step();
            chk("t4_x_frozen", alu_func, ALU_SUB);
        end
        chk("t4_r_drained", rsp_valid, 0);
        hold = 1'b0;
        step();
        set_req0(0, ALU_NONE, 0, 0, 0);
        chk("t4_resume_valid", rsp_valid, 1);
        chk("t4_resume_result", rsp_result, 32'd5);
        chk("t4_resume_tag", rsp_tag, 9);
        repeat (3) step();

        // Reset with both stages full discards the work
        rsp_ready = 1'b0;
        set_req0(1, ALU_ADD, 32'd1, 32'd2, 5'd1);
        step(); step();
        set_req0(0, ALU_NONE, 0, 0, 0);
        rst_n = 1'b0;
        step();
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_alu_func", alu_func, ALU_NONE);
        rst_n = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t5_no_stale", rsp_valid, 0);
        end

        // req1 alone: SUB wraps, undefined func code passes through
        set_req1(1, ALU_SUB, 32'd3, 32'd5, 5'd31);
        step();
        set_req1(1, 4'hF, 32'h1234, 32'h5678, 5'd2);
        step();
        set_req1(0, ALU_NONE, 0, 0, 0);
        chk("t6_result", rsp_result, 32'hFFFF_FFFE);
        chk("t6_id", rsp_id, 1);
        chk("t6_tag", rsp_tag, 31);
        chk("t6_undef_func", alu_func, 4'hF);
        repeat (2) step();

        // Random traffic with holds, backpressure and occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 499) != 0);
            hold      = ($urandom_range(0, 9) == 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            if (!req0_valid || hs0)
                set_req0($urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), $urandom, $urandom,
                         TAG_W'($urandom_range(0, 31)));
            if (!req1_valid || hs1)
                set_req1($urandom_range(0, 99) < 40, 4'($urandom_range(0, 15)), $urandom, $urandom,
                         TAG_W'($urandom_range(0, 31)));
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
